// File: rtl/switch_stream_pkg.sv
// Shared types and helpers for the switch-port stream adapters.
package switch_stream_pkg;

  localparam int BUFFER_DEPTH = 2;

  typedef logic [1:0] occupancy_t;

  // The end-of-packet flag only means something when the word carries framing.
  function automatic logic word_is_last(input logic word_msb, input bit packet_mode);
    return packet_mode & word_msb;
  endfunction

endpackage

// File: rtl/stream_two_entry_buffer.sv
// Two-entry register FIFO. The head entry drives the output directly, so the
// read data is always a flop output.
module stream_two_entry_buffer
  import switch_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output occupancy_t       occupancy
);

  logic [WIDTH-1:0] tail_data;

  // NOTE: the entries are reset (unlike a RAM) so the head reads 0 straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_data <= '0;
      tail_data <= '0;
      occupancy <= '0;
    end else if (push && pop) begin
      // Occupancy is unchanged; the word either refills the head or queues behind it.
      if (occupancy == occupancy_t'(BUFFER_DEPTH)) begin
        head_data <= tail_data;
        tail_data <= push_data;
      end else begin
        head_data <= push_data;
        if (occupancy == '0) occupancy <= 2'd1;
      end
    end else if (push) begin
      if (occupancy == '0) begin
        head_data <= push_data;
        occupancy <= 2'd1;
      end else if (occupancy == 2'd1) begin
        tail_data <= push_data;
        occupancy <= 2'd2;
      end
    end else if (pop && occupancy != '0) begin
      head_data <= tail_data;
      occupancy <= occupancy - 2'd1;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a standard-mode synchronous FIFO (data one cycle after read enable)
// into a registered valid/ready stream at one word per cycle.
module fifo_stream_reader
  import switch_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int PACKET_MODE = 1,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              fifo_empty,
  output logic                              fifo_read_enable,
  input  logic [DATA_WIDTH-1:0]             fifo_read_data,
  input  logic                              fifo_read_data_valid,
  output logic [DATA_WIDTH-PACKET_MODE-1:0] stream_data,
  output logic                              stream_last,
  output logic                              stream_valid,
  input  logic                              stream_ready,
  output logic [COUNT_WIDTH-1:0]            packet_count,
  output logic                              protocol_error
);

  localparam int PAYLOAD_WIDTH = DATA_WIDTH - PACKET_MODE;

  logic                  in_flight;
  logic                  push;
  logic                  pop;
  logic [2:0]            pending;
  occupancy_t            occupancy;
  logic [DATA_WIDTH-1:0] head_word;

  assign pop  = stream_valid & stream_ready;
  assign push = fifo_read_data_valid & in_flight;

  // Count a word leaving this cycle as free space so a full pipe keeps issuing.
  assign pending          = 3'(occupancy) + 3'(in_flight) - 3'(pop);
  assign fifo_read_enable = !fifo_empty && (pending < 3'(BUFFER_DEPTH));

  stream_two_entry_buffer #(
    .WIDTH(DATA_WIDTH)
  ) u_buffer (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_data(fifo_read_data),
    .pop      (pop),
    .head_data(head_word),
    .occupancy(occupancy)
  );

  assign stream_valid = (occupancy != '0);
  assign stream_data  = head_word[PAYLOAD_WIDTH-1:0];
  assign stream_last  = word_is_last(head_word[DATA_WIDTH-1], PACKET_MODE != 0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_flight      <= 1'b0;
      protocol_error <= 1'b0;
      packet_count   <= '0;
    end else begin
      in_flight <= fifo_read_enable;
      if (fifo_read_data_valid && !in_flight) protocol_error <= 1'b1;
      if (pop && stream_last) packet_count <= packet_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: behavioural standard-mode FIFO feeding the reader, with a
// stream monitor and an in-order expectation queue.
module tb_fifo_stream_reader;

  localparam int FIFO_DEPTH = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty;
  logic        fifo_read_enable, fifo_read_enable_b;
  logic [15:0] fifo_read_data;
  logic        fifo_read_data_valid;
  logic [14:0] stream_data, stream_data_b;
  logic        stream_last, stream_last_b;
  logic        stream_valid, stream_valid_b;
  logic        stream_ready = 1'b0;
  logic [31:0] packet_count;
  logic [1:0]  packet_count_b;
  logic        protocol_error, protocol_error_b;

  always #5 clock = ~clock;

  fifo_stream_reader #(.DATA_WIDTH(16), .PACKET_MODE(1), .COUNT_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_read_enable(fifo_read_enable), .fifo_read_data(fifo_read_data),
    .fifo_read_data_valid(fifo_read_data_valid), .stream_data(stream_data),
    .stream_last(stream_last), .stream_valid(stream_valid), .stream_ready(stream_ready),
    .packet_count(packet_count), .protocol_error(protocol_error)
  );

  // Narrow counter instance shadows the main one to exercise wrap-around.
  fifo_stream_reader #(.DATA_WIDTH(16), .PACKET_MODE(1), .COUNT_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_read_enable(fifo_read_enable_b), .fifo_read_data(fifo_read_data),
    .fifo_read_data_valid(fifo_read_data_valid), .stream_data(stream_data_b),
    .stream_last(stream_last_b), .stream_valid(stream_valid_b), .stream_ready(stream_ready),
    .packet_count(packet_count_b), .protocol_error(protocol_error_b)
  );

  // ---------------- FIFO model ----------------
  logic [15:0] mem [FIFO_DEPTH];
  int          wr_ptr, rd_ptr;
  logic [15:0] fifo_rdata;
  logic        fifo_rdv;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic        force_rdv = 1'b0;
  logic [15:0] force_data = '0;

  assign fifo_empty           = (wr_ptr == rd_ptr);
  assign fifo_read_data_valid = fifo_rdv | force_rdv;
  assign fifo_read_data       = force_rdv ? force_data : fifo_rdata;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 0; rd_ptr <= 0; fifo_rdv <= 1'b0; fifo_rdata <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr % FIFO_DEPTH] <= wr_data;
        wr_ptr <= wr_ptr + 1;
      end
      if (fifo_read_enable && wr_ptr != rd_ptr) begin
        fifo_rdata <= mem[rd_ptr % FIFO_DEPTH];
        rd_ptr     <= rd_ptr + 1;
        fifo_rdv   <= 1'b1;
      end else begin
        fifo_rdv <= 1'b0;
      end
    end
  end

  // ---------------- Monitor (samples on the falling edge) ----------------
  logic [14:0] rx_data [$];
  bit          rx_last [$];
  int          rx_cyc  [$];
  bit          re_hist [$];
  int          efall   [$];
  int          cyc = 0;
  int          occ_model = 0;
  int          overflow_events = 0;
  bit          prev_empty = 1'b1;

  always @(negedge clock) begin
    if (reset) begin
      occ_model = 0;
    end else begin
      cyc++;
      re_hist.push_back(fifo_read_enable);
      if (prev_empty && !fifo_empty) efall.push_back(cyc);
      if (fifo_rdv) begin
        if (occ_model >= 2) overflow_events++;
        occ_model++;
      end
      if (stream_valid && stream_ready) begin
        rx_data.push_back(stream_data);
        rx_last.push_back(stream_last);
        rx_cyc.push_back(cyc);
        occ_model--;
      end
    end
    prev_empty = fifo_empty;
  end

  // ---------------- Checking helpers ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rx_ptr   = 0;
  logic [15:0] exp_q [$];
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_ready) stream_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic write_word(input logic [15:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int target = rx_ptr + n;
    for (int i = 0; i < budget && rx_data.size() < target; i++) step();
    check({tag, " beats arrived"}, 64'(rx_data.size() >= target), 64'd1);
  endtask

  task automatic drain_check(input string tag, input int n, input bit per_beat);
    int          bad = 0;
    logic [15:0] e;
    for (int i = 0; i < n && rx_ptr < rx_data.size(); i++) begin
      e = exp_q.pop_front();
      if (per_beat) begin
        check($sformatf("%s data[%0d]", tag, i), 64'(rx_data[rx_ptr]), 64'(e[14:0]));
        check($sformatf("%s last[%0d]", tag, i), 64'(rx_last[rx_ptr]), 64'(e[15]));
      end else if (rx_data[rx_ptr] !== e[14:0] || rx_last[rx_ptr] !== e[15]) begin
        bad++;
      end
      rx_ptr++;
    end
    if (!per_beat) check({tag, " order mismatches"}, 64'(bad), 64'd0);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    rx_ptr = rx_data.size();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " stream_valid"},     64'(stream_valid),     64'd0);
    check({tag, " stream_data"},      64'(stream_data),      64'd0);
    check({tag, " stream_last"},      64'(stream_last),      64'd0);
    check({tag, " packet_count"},     64'(packet_count),     64'd0);
    check({tag, " protocol_error"},   64'(protocol_error),   64'd0);
    check({tag, " fifo_read_enable"}, 64'(fifo_read_enable), 64'd0);
  endtask

  // ---------------- Directed sequence ----------------
  initial begin
    int          re_base, ebase, ones, first_one, last_one, pkts;
    logic [15:0] w;
    bit          exp_last [7];
    logic [1:0]  exp_pc [5];

    // Reset state
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();

    // Burst of 8 words with the consumer always ready
    stream_ready = 1'b1;
    re_base = re_hist.size();
    ebase   = efall.size();
    for (int i = 0; i < 8; i++) write_word(16'h1230 + 16'(i));
    wait_beats("burst", 8, 40);
    step();
    ones = 0; first_one = -1; last_one = -1;
    for (int i = re_base; i < re_hist.size(); i++)
      if (re_hist[i]) begin
        ones++;
        if (first_one < 0) first_one = i;
        last_one = i;
      end
    check("burst read_enable count", 64'(ones), 64'd8);
    check("burst read_enable span", 64'(last_one - first_one), 64'd7);
    check("burst latency", 64'(rx_cyc[rx_ptr] - efall[ebase]), 64'd2);
    check("burst back-to-back", 64'(rx_cyc[rx_ptr + 7] - rx_cyc[rx_ptr]), 64'd7);
    drain_check("burst", 8, 1'b1);
    check("burst packet_count", 64'(packet_count), 64'd0);

    // Backpressure: 5 words queued, consumer stalled
    stream_ready = 1'b0;
    re_base = re_hist.size();
    for (int i = 0; i < 5; i++) write_word(16'h0a50 + 16'(i));
    for (int i = 0; i < 8; i++) step();
    ones = 0;
    for (int i = re_base; i < re_hist.size(); i++) ones += int'(re_hist[i]);
    check("stall reads issued", 64'(ones), 64'd2);
    check("stall occupancy", 64'(dut.occupancy), 64'd2);
    check("stall read_enable", 64'(fifo_read_enable), 64'd0);
    check("stall valid", 64'(stream_valid), 64'd1);
    check("stall data", 64'(stream_data), 64'h0a50);
    for (int i = 0; i < 3; i++) step();
    check("stall data held", 64'(stream_data), 64'h0a50);
    stream_ready = 1'b1;
    wait_beats("stall release", 5, 40);
    drain_check("stall release", 5, 1'b1);

    // 1000 random words with a random consumer
    reset_dut();
    pkts = 0;
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      w = 16'($urandom);
      pkts += int'(w[15]);
      write_word(w);
    end
    wait_beats("random", 1000, 6000);
    rand_ready   = 1'b0;
    stream_ready = 1'b1;
    step();
    drain_check("random", 1000, 1'b0);
    check("random overflow events", 64'(overflow_events), 64'd0);
    check("random packet_count", 64'(packet_count), 64'(pkts));

    // Packets of length 1, 4, 2
    reset_dut();
    exp_last = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) write_word({exp_last[i], 15'h0100 + 15'(i)});
    wait_beats("packets", 7, 40);
    drain_check("packets", 7, 1'b1);
    check("packets packet_count", 64'(packet_count), 64'd3);

    // 2-bit counter wraps
    reset_dut();
    exp_pc = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int p = 0; p < 5; p++) begin
      write_word(16'h8000 | 16'(p));
      wait_beats("wrap", 1, 20);
      drain_check("wrap", 1, 1'b1);
      check($sformatf("wrap packet_count[%0d]", p), 64'(packet_count_b), 64'(exp_pc[p]));
    end

    // Stray read-data-valid with nothing in flight
    reset_dut();
    check("stray before", 64'(protocol_error), 64'd0);
    force_data = 16'h7abc;
    force_rdv  = 1'b1;
    step();
    force_rdv = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("stray protocol_error", 64'(protocol_error), 64'd1);
    check("stray not emitted valid", 64'(stream_valid), 64'd0);
    check("stray not emitted beats", 64'(rx_data.size()), 64'(rx_ptr));
    write_word(16'h0042);
    wait_beats("after stray", 1, 20);
    drain_check("after stray", 1, 1'b1);
    check("stray sticky", 64'(protocol_error), 64'd1);

    // Reset mid-stream with words buffered and queued
    stream_ready = 1'b0;
    for (int i = 0; i < 3; i++) write_word(16'h0dd0 + 16'(i));
    for (int i = 0; i < 4; i++) step();
    check("midreset valid before", 64'(stream_valid), 64'd1);
    reset = 1'b1;
    step();
    check_all_zero("midreset");
    step();
    reset = 1'b0;
    exp_q.delete();
    rx_ptr = rx_data.size();
    stream_ready = 1'b1;
    for (int i = 0; i < 3; i++) write_word(16'h0330 + 16'(i));
    wait_beats("resume", 3, 30);
    drain_check("resume", 3, 1'b1);
    for (int i = 0; i < 6; i++) step();
    check("resume no stale beats", 64'(rx_data.size()), 64'(rx_ptr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
